// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit timing.
// Used by both the transmit serializer and the receive path.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// A clear restarts the count at zero on the next edge.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clearing on the terminal count keeps the counter from ever wrapping on its own.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB-first as start,
// 8 data bits, optional parity and 1 or 2 stop bits on a registered, idle-high line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_out
);

  localparam logic [2:0] DATA_LAST = 3'(DATA_W - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic       ODD_SEL   = (PARITY_ODD != 0);

  uart_state_e       state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [2:0]        bit_cnt_q;
  logic              parity_q;
  logic              tx_out_q;
  logic              ready_q;
  logic              bit_done;
  logic              baud_clr;

  // Holding the counter cleared in IDLE makes START begin its first bit at count 0.
  assign baud_clr = (state_q == ST_IDLE) | bit_done;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst_i     (Rst),
    .clr_i     (baud_clr),
    .bit_done_o(bit_done)
  );

  // tx_out is registered from the current state, so the line lags the FSM by one
  // cycle: the start bit appears on the edge after the handshake edge.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_out_q <= 1'b1;
          if (tx_valid) begin
            shreg_q  <= tx_data;
            parity_q <= (^tx_data) ^ ODD_SEL;
            state_q  <= ST_START;
            ready_q  <= 1'b0;
          end
        end
        ST_START: begin
          tx_out_q <= 1'b0;
          if (bit_done) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          tx_out_q <= shreg_q[0];
          if (bit_done) begin
            shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          tx_out_q <= parity_q;
          if (bit_done) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx_out_q <= 1'b1;
          if (bit_done) begin
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_IDLE;
              ready_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          tx_out_q  <= 1'b1;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = ready_q;
  assign tx_busy  = ~ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parity/stop-bit variants share one stimulus
// stream and are compared every cycle against a frame-timeline reference model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int ND  = 4;
  localparam int PE [ND] = '{0, 1, 1, 0};
  localparam int PO [ND] = '{0, 0, 1, 0};
  localparam int SB [ND] = '{1, 1, 1, 2};

  logic          clk = 1'b0;
  logic          Rst;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [ND-1:0] tx_ready;
  logic [ND-1:0] tx_busy;
  logic [ND-1:0] tx_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    uart_tx_serializer #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE[gi]),
      .PARITY_ODD  (PO[gi]),
      .STOP_BITS   (SB[gi])
    ) u_dut (
      .clk     (clk),
      .Rst     (Rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready[gi]),
      .tx_busy (tx_busy[gi]),
      .tx_out  (tx_out[gi])
    );
  end

  task automatic expect_eq(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b expected=%b", tag, $time, act, exp);
    end
  endtask

  // Frame as a list of line bits: start, data LSB-first, optional parity, stop ones.
  function automatic logic [11:0] frame_bits(input logic [7:0] b, input int pe, input int po);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (pe != 0) f[9] = (^b) ^ (po != 0);
    return f;
  endfunction

  function automatic int frame_len(input int i);
    return (10 + PE[i] + SB[i] - 1) * CPB;
  endfunction

  // Reference: t counts edges since the accepting edge; the line replays the
  // frame bits from edge 1 to edge N, busy covers edges 0..N-1.
  logic        active [ND];
  int          t      [ND];
  logic [11:0] fb     [ND];
  logic [7:0]  acc_byte [ND];
  int          n_frames [ND];

  initial begin
    for (int i = 0; i < ND; i++) begin
      active[i] = 1'b0;
      t[i] = 0;
      fb[i] = '1;
      n_frames[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (Rst) begin
        active[i] = 1'b0;
      end else if (!(active[i] && t[i] < frame_len(i)) && tx_valid) begin
        active[i]   = 1'b1;
        t[i]        = 0;
        fb[i]       = frame_bits(tx_data, PE[i], PO[i]);
        acc_byte[i] = tx_data;
        n_frames[i]++;
        $display("tb: dut%0d accepts 0x%02h at t=%0t (frame %0d)", i, tx_data, $time, n_frames[i]);
      end else if (active[i] && t[i] <= frame_len(i)) begin
        t[i]++;
      end
    end
    #1;
    for (int i = 0; i < ND; i++) begin
      logic exp_busy;
      logic exp_out;
      exp_busy = active[i] && (t[i] < frame_len(i));
      exp_out  = (active[i] && t[i] >= 1 && t[i] <= frame_len(i)) ? fb[i][(t[i] - 1) / CPB] : 1'b1;
      expect_eq($sformatf("dut%0d_tx_out", i), tx_out[i], exp_out);
      expect_eq($sformatf("dut%0d_tx_busy", i), tx_busy[i], exp_busy);
      expect_eq($sformatf("dut%0d_tx_ready", i), tx_ready[i], ~exp_busy);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_data = 8'($urandom);
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  initial begin
    Rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    idle(20);

    pulse(8'hA5);
    idle(60);

    pulse(8'h07);
    idle(60);

    // Held valid: back-to-back frames; data switches to 0x0F after the first accept.
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'h0F;
    repeat (70) @(negedge clk);
    tx_valid = 1'b0;
    idle(60);

    // Reset about ten cycles into a frame, then a clean frame.
    pulse(8'h5A);
    idle(8);
    @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    pulse(8'h3C);
    idle(60);

    // A valid pulse while busy must be ignored.
    pulse(8'h81);
    idle(15);
    pulse(8'hFF);
    idle(60);

    repeat (1500) begin
      @(negedge clk);
      tx_data  = 8'($urandom);
      tx_valid = ($urandom_range(0, 3) == 0);
      Rst      = ($urandom_range(0, 299) == 0);
    end
    Rst      = 1'b0;
    tx_valid = 1'b0;
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
